// File: rtl/serial_subtractor_4bit_seq.sv
// Bit-serial subtractor: {bout,d} = a - b - bin, one bit per clock, LSB first,
// through a single full-subtractor cell, with a start/busy/done handshake.
module serial_subtractor_4bit_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;      // minuend shift register, consumed from bit 0
  logic [WIDTH-1:0] b_q;      // subtrahend shift register, consumed from bit 0
  logic             br_q;     // running borrow between bit slices
  logic [WIDTH-1:0] res_q;    // partial difference, filled from the MSB end
  logic [CNT_W-1:0] cnt_q;    // index of the bit slice being processed
  logic [WIDTH-1:0] d_q;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;

  // Full-subtractor cell working on the current LSBs and the running borrow.
  logic             diff_bit;
  logic             borrow_d;
  logic [WIDTH-1:0] res_d;

  assign diff_bit = a_q[0] ^ b_q[0] ^ br_q;
  assign borrow_d = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  assign res_d    = {diff_bit, res_q[WIDTH-1:1]};

  // Control FSM with datapath registers; outputs are registered so d/bout
  // only move on completion and busy/done are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: every register here uses non-blocking assignment so all reads in
      // this block see the pre-edge values, regardless of statement order.
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= bin;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end

        SHIFT: begin
          // start is deliberately ignored here: no queuing of requests.
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= borrow_d;
          res_q <= res_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            d_q     <= res_d;
            bout_q  <= borrow_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d    = d_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor_4bit_seq.sv
// Self-checking bench for serial_subtractor_4bit_seq: directed cases from the
// test plan, random operations and an exhaustive sweep against a
// plain-arithmetic reference of a - b - bin at WIDTH+1 bits.
module tb_serial_subtractor_4bit_seq;

  localparam int WIDTH = 4;
  localparam int TIMEOUT = 20;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;

  int n_cmp = 0;
  int n_err = 0;

  // Result currently expected on d/bout between completions.
  logic [WIDTH-1:0] held_d;
  logic             held_b;

  serial_subtractor_4bit_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {bout,d} is a - b - bin computed in WIDTH+1-bit arithmetic.
  function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] av,
                                             input logic [WIDTH-1:0] bv,
                                             input logic             cv);
    int diff;
    diff = int'(av) - int'(bv) - int'(cv);
    return (WIDTH+1)'(diff);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present a request for the next rising edge.
  task automatic drive_start(input logic [WIDTH-1:0] av,
                             input logic [WIDTH-1:0] bv, input logic cv);
    start = 1'b1;
    a     = av;
    b     = bv;
    bin   = cv;
  endtask

  // Called at the negedge where start is high. Follows the operation through
  // to its done pulse, checking busy, held outputs, latency and the result.
  // With poke set, a new request is pulsed mid-operation and must be ignored.
  // Returns at the negedge of the done cycle.
  task automatic wait_result(input string tag, input logic [WIDTH-1:0] av,
                             input logic [WIDTH-1:0] bv, input logic cv,
                             input bit poke);
    logic [WIDTH:0] exp;
    bit seen;
    exp  = ref_sub(av, bv, cv);
    seen = 1'b0;
    @(posedge clk);
    for (int n = 1; n <= TIMEOUT; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        bin   = 1'($urandom);
      end
      if (poke && n == 2) drive_start(WIDTH'($urandom), WIDTH'($urandom), 1'b1);
      if (poke && n == 3) start = 1'b0;
      if (done) begin
        seen = 1'b1;
        check({tag, ".latency"}, n, WIDTH + 1);
        check({tag, ".busy_at_done"}, busy, 1'b0);
        check({tag, ".d"}, d, exp[WIDTH-1:0]);
        check({tag, ".bout"}, bout, exp[WIDTH]);
        held_d = exp[WIDTH-1:0];
        held_b = exp[WIDTH];
        break;
      end else begin
        check({tag, ".busy"}, busy, 1'b1);
        check({tag, ".d_held"}, d, held_d);
        check({tag, ".bout_held"}, bout, held_b);
      end
    end
    if (!seen) check({tag, ".timeout"}, 1'b0, 1'b1);
  endtask

  // Idle cycles with start low: no done pulse, not busy, outputs held.
  task automatic idle_check(input string tag, input int cycles);
    start = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check({tag, ".done"}, done, 1'b0);
      check({tag, ".busy"}, busy, 1'b0);
      check({tag, ".d"}, d, held_d);
      check({tag, ".bout"}, bout, held_b);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic             rc;

    // Reset with start held high.
    rst_n  = 1'b0;
    start  = 1'b1;
    a      = 4'd9;
    b      = 4'd3;
    bin    = 1'b0;
    held_d = '0;
    held_b = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.busy", busy, 1'b0);
    check("reset.done", done, 1'b0);
    check("reset.d", d, 0);
    check("reset.bout", bout, 1'b0);
    start = 1'b0;
    rst_n = 1'b1;
    idle_check("post_reset", 8);

    // Basic subtraction.
    @(negedge clk);
    drive_start(4'd9, 4'd3, 1'b0);
    wait_result("basic", 4'd9, 4'd3, 1'b0, 1'b0);
    idle_check("basic_after", 2);

    // Borrow cases.
    drive_start(4'd3, 4'd9, 1'b0);
    wait_result("borrow_3_9", 4'd3, 4'd9, 1'b0, 1'b0);
    idle_check("borrow_3_9_after", 1);
    drive_start(4'd0, 4'd0, 1'b1);
    wait_result("borrow_0_0_1", 4'd0, 4'd0, 1'b1, 1'b0);
    idle_check("borrow_0_0_1_after", 1);
    drive_start(4'd15, 4'd15, 1'b1);
    wait_result("borrow_15_15_1", 4'd15, 4'd15, 1'b1, 1'b0);
    idle_check("borrow_15_15_1_after", 1);

    // Start pulsed while busy is ignored; exactly one done pulse follows.
    drive_start(4'd9, 4'd3, 1'b0);
    wait_result("ignored_start", 4'd9, 4'd3, 1'b0, 1'b1);
    idle_check("ignored_start_after", 4);

    // Back-to-back: request in the DONE cycle.
    drive_start(4'd9, 4'd3, 1'b0);
    wait_result("b2b_first", 4'd9, 4'd3, 1'b0, 1'b0);
    drive_start(4'd12, 4'd5, 1'b1);
    wait_result("b2b_second", 4'd12, 4'd5, 1'b1, 1'b0);
    idle_check("b2b_after", 2);

    // Reset asserted mid-operation aborts with no done pulse.
    drive_start(4'd9, 4'd3, 1'b0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset.busy", busy, 1'b0);
    check("midreset.done", done, 1'b0);
    check("midreset.d", d, 0);
    check("midreset.bout", bout, 1'b0);
    held_d = '0;
    held_b = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_check("midreset_after", 8);

    // Random operations, back-to-back.
    drive_start(4'd0, 4'd0, 1'b0);
    wait_result("rand_seed_op", 4'd0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      drive_start(ra, rb, rc);
      wait_result("random", ra, rb, rc, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle_check("random_gap", 1);
    end
    idle_check("random_after", 1);

    // Exhaustive sweep of every (a, b, bin) combination.
    for (int k = 0; k < (1 << (2 * WIDTH + 1)); k++) begin
      ra = WIDTH'(k);
      rb = WIDTH'(k >> WIDTH);
      rc = 1'(k >> (2 * WIDTH));
      drive_start(ra, rb, rc);
      wait_result("sweep", ra, rb, rc, 1'b0);
    end
    idle_check("sweep_after", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_4bit_seq.md
Name: serial_subtractor_4bit_seq

Overview:
- Bit-serial subtractor, the inverse operation of the team's 4-bit dataflow full adder.
- Computes {bout,d} = a - b - bin, processing one bit per clock, LSB first, through a single full-subtractor cell.
- Has a start/busy/done handshake.
- Used in area-constrained datapaths and as a cross-check against the adder: (a - b) + b = a.

Parameters:
WIDTH, 4, operand/result width in bits (must be >= 2).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled on a rising clk edge when accepting.
a  input  WIDTH  minuend; captured with start.
b  input  WIDTH  subtrahend; captured with start.
bin  input  1  borrow-in; captured with start.
busy  output  1  high while an operation is in progress.
done  output  1  single-cycle pulse: d and bout have just been updated.
d  output  WIDTH  difference; holds the last completed result.
bout  output  1  borrow-out of the last completed result; 1 when a < b + bin (unsigned).

Behaviour:
- Reset (rst_n low, async): state=IDLE; busy=0, done=0, d=0, bout=0; operand/shift registers and bit counter cleared.
- FSM states: IDLE, SHIFT, DONE.
- Acceptance: start is accepted in IDLE and in DONE; it is ignored in SHIFT (no queuing, no error).
- On accept: latch a, b, bin into internal shift registers; counter=0; go to SHIFT; busy=1 from the next cycle.
- SHIFT, each edge, on the current LSBs ai, bi and running borrow br:
  - di = ai ^ bi ^ br
  - br_next = (~ai & bi) | (~(ai ^ bi) & br)
  - di is shifted into the result register from the MSB end; operands shift right; counter increments.
- After exactly WIDTH SHIFT edges:
  - the result register is copied to d, and br_next to bout;
  - state=DONE; done=1; busy=0.
- DONE lasts one cycle, then IDLE (or SHIFT again if start is high in DONE, giving back-to-back operation).
- Latency: start sampled at edge 0 -> done high in the cycle after edge WIDTH; the new d/bout are visible in that same cycle.
- Throughput: one result per WIDTH+1 cycles.
- d and bout change only at completion; they are never partially updated while busy.
- Arithmetic:
  - Result is modulo 2^WIDTH.
  - bout is the true unsigned borrow.
  - {bout,d} read as a two's-complement WIDTH+1-bit value equals a - b - bin exactly.
- Operands a, b, bin may change freely after acceptance without affecting the operation in flight.
- Reset asserted mid-operation: abort immediately; no done pulse; outputs return to reset values.
- start held high continuously: one operation every WIDTH+1 cycles, each using the operands present on its accepting edge.
- busy and done are never high in the same cycle.

Test Plan:
- Reset: rst_n=0 with start=1 -> busy=0, done=0, d=0, bout=0. After release, no done pulse until a start is accepted.
- Basic: a=9, b=3, bin=0 -> done exactly 5 cycles after the start edge with WIDTH=4; d=6, bout=0; busy high for the 4 intervening cycles.
- Borrow cases:
  - a=3, b=9, bin=0 -> d=10 (4'b1010), bout=1.
  - a=0, b=0, bin=1 -> d=15, bout=1.
  - a=15, b=15, bin=1 -> d=15, bout=1.
- Ignored start: start pulsed with new operands while busy -> the in-flight result (9-3=6) is unaffected; exactly one done pulse is produced.
- Back-to-back: start high in the DONE cycle with a=12, b=5, bin=1 -> second done 5 cycles later with d=6, bout=0. The first result stays on d until then.
- Reset mid-op / exhaustive: rst_n pulsed low during SHIFT -> no done pulse, d=0, bout=0. Then sweep all 512 (a,b,bin) combinations and compare {bout,d} against a-b-bin computed at WIDTH+1 bits.
